// File: rtl/comparador_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// one-hot result encoding {igual, maior, menor}.
package comparador_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   typedef struct packed {
      logic igual;
      logic maior;
      logic menor;
   } resultado_t;

   localparam resultado_t RES_NENHUM = 3'b000;
   localparam resultado_t RES_IGUAL  = 3'b100;
   localparam resultado_t RES_MAIOR  = 3'b010;
   localparam resultado_t RES_MENOR  = 3'b001;

   // Selects the strict-order result from a digit comparison that differed.
   function automatic resultado_t res_desigual(input logic gt);
      return gt ? RES_MAIOR : RES_MENOR;
   endfunction

endpackage

// File: rtl/comparador_digito.sv
// Combinational unsigned comparator for one DIGITO-bit digit; lt = !eq & !gt.
module comparador_digito #(
   parameter int unsigned DIGITO = 4
) (
   input  logic [DIGITO-1:0] a,
   input  logic [DIGITO-1:0] b,
   output logic              eq,
   output logic              gt
);

   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/comparador_magnitude_seq.sv
// Digit-serial magnitude comparator: walks both operands MSB-first, DIGITO bits
// per clock, stopping at the first differing digit. Signed mode uses offset binary.
module comparador_magnitude_seq
   import comparador_pkg::*;
#(
   parameter int unsigned LARGURA = 16,
   parameter int unsigned DIGITO  = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               inicio,
   input  logic [LARGURA-1:0] A,
   input  logic [LARGURA-1:0] B,
   input  logic               com_sinal,
   output logic               ocupado,
   output logic               pronto,
   output logic               igual,
   output logic               maior,
   output logic               menor
);

   localparam int unsigned N  = LARGURA / DIGITO;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

   estado_t            estado_q, estado_d;
   logic [LARGURA-1:0] a_q, a_d;
   logic [LARGURA-1:0] b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   resultado_t         res_q, res_d;
   logic               ocupado_q, ocupado_d;
   logic               pronto_q, pronto_d;

   logic               dig_eq;
   logic               dig_gt;
   logic [LARGURA-1:0] a_map;
   logic [LARGURA-1:0] b_map;

   comparador_digito #(
      .DIGITO (DIGITO)
   ) u_digito (
      .a  (a_q[LARGURA-1 -: DIGITO]),
      .b  (b_q[LARGURA-1 -: DIGITO]),
      .eq (dig_eq),
      .gt (dig_gt)
   );

   // Flipping the sign bit maps two's complement onto an order-preserving unsigned range.
   always_comb begin
      a_map = A;
      b_map = B;
      if (com_sinal) begin
         a_map[LARGURA-1] = ~A[LARGURA-1];
         b_map[LARGURA-1] = ~B[LARGURA-1];
      end
   end

   always_comb begin
      estado_d  = estado_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      ocupado_d = 1'b0;
      pronto_d  = 1'b0;

      case (estado_q)
         IDLE: begin
            if (inicio) begin
               a_d       = a_map;
               b_d       = b_map;
               cnt_d     = '0;
               res_d     = RES_NENHUM;
               ocupado_d = 1'b1;
               estado_d  = COMPARA;
            end
         end

         COMPARA: begin
            if (!dig_eq) begin
               res_d    = res_desigual(dig_gt);
               pronto_d = 1'b1;
               estado_d = FIM;
            end else if (cnt_q == ULTIMO) begin
               res_d    = RES_IGUAL;
               pronto_d = 1'b1;
               estado_d = FIM;
            end else begin
               a_d       = a_q << DIGITO;
               b_d       = b_q << DIGITO;
               cnt_d     = CW'(cnt_q + CW'(1));
               ocupado_d = 1'b1;
            end
         end

         FIM: begin
            estado_d = IDLE;
         end

         default: begin
            estado_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado_q  <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         res_q     <= RES_NENHUM;
         ocupado_q <= 1'b0;
         pronto_q  <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         ocupado_q <= ocupado_d;
         pronto_q  <= pronto_d;
      end
   end

   assign ocupado = ocupado_q;
   assign pronto  = pronto_q;
   assign igual   = res_q.igual;
   assign maior   = res_q.maior;
   assign menor   = res_q.menor;

endmodule

// File: tb/tb_comparador_magnitude_seq.sv
// Bench for comparador_magnitude_seq: 16/4 and 8/1 instances checked against
// an arithmetic reference model of result and latency.
module tb_comparador_magnitude_seq;

   logic        clock;
   logic        reset_n;

   logic        ini16, sg16, oc16, pr16, ig16, ma16, me16;
   logic [15:0] a16, b16;
   logic        ini8, sg8, oc8, pr8, ig8, ma8, me8;
   logic [7:0]  a8, b8;

   int vectors;
   int miscompares;

   comparador_magnitude_seq #(.LARGURA(16), .DIGITO(4)) dut16 (
      .clock     (clock),
      .reset_n   (reset_n),
      .inicio    (ini16),
      .A         (a16),
      .B         (b16),
      .com_sinal (sg16),
      .ocupado   (oc16),
      .pronto    (pr16),
      .igual     (ig16),
      .maior     (ma16),
      .menor     (me16)
   );

   comparador_magnitude_seq #(.LARGURA(8), .DIGITO(1)) dut8 (
      .clock     (clock),
      .reset_n   (reset_n),
      .inicio    (ini8),
      .A         (a8),
      .B         (b8),
      .com_sinal (sg8),
      .ocupado   (oc8),
      .pronto    (pr8),
      .igual     (ig8),
      .maior     (ma8),
      .menor     (me8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference result from integer values: {igual, maior, menor}.
   function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int lw);
      longint va;
      longint vb;
      va = longint'(a);
      vb = longint'(b);
      if (s && a[lw-1]) va = va - (longint'(1) << lw);
      if (s && b[lw-1]) vb = vb - (longint'(1) << lw);
      if (va == vb) return 3'b100;
      else if (va > vb) return 3'b010;
      else return 3'b001;
   endfunction

   // Cycles from acceptance to pronto: 2 + index of first differing digit, or N+1.
   function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                  input int lw, input int dw);
      logic [31:0] x;
      logic [31:0] mdig;
      x    = a ^ b;
      mdig = (32'h1 << dw) - 32'h1;
      for (int j = 0; j < lw / dw; j++)
         if (((x >> (lw - (j + 1) * dw)) & mdig) != 32'h0) return 2 + j;
      return lw / dw + 1;
   endfunction

   task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ini);
      if (w == 1) begin
         a8 = a[7:0]; b8 = b[7:0]; sg8 = s; ini8 = ini;
      end else begin
         a16 = a[15:0]; b16 = b[15:0]; sg16 = s; ini16 = ini;
      end
   endtask

   task automatic sample(input int w, output logic oc, output logic pr, output logic [2:0] res);
      if (w == 1) begin
         oc = oc8; pr = pr8; res = {ig8, ma8, me8};
      end else begin
         oc = oc16; pr = pr16; res = {ig16, ma16, me16};
      end
   endtask

   // One full comparison; optionally keeps inicio high with fresh operands until pronto.
   task automatic test_compare(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                               input logic s, input string nome, input bit segura);
      int lw, dw, n, exp_lat, got_lat, oc_cnt, pr_cnt;
      logic [31:0] m, a, b;
      logic [2:0] exp_res, res_pr, res;
      logic oc, pr;
      lw = (w == 1) ? 8 : 16;
      dw = (w == 1) ? 1 : 4;
      n  = lw / dw;
      m  = (32'h1 << lw) - 32'h1;
      a  = a_in & m;
      b  = b_in & m;
      exp_lat = ref_lat(a, b, lw, dw);
      exp_res = ref_res(a, b, s, lw);
      @(negedge clock);
      drive(w, a, b, s, 1'b1);
      got_lat = 0; oc_cnt = 0; pr_cnt = 0; res_pr = 3'b000;
      for (int cyc = 1; cyc <= n + 4; cyc++) begin
         @(negedge clock);
         sample(w, oc, pr, res);
         if (cyc == 1) begin
            vectors++;
            if (res !== 3'b000) begin
               miscompares++;
               $display("FAIL %s clear_on_start: got %b expected 000", nome, res);
            end
         end
         if (oc) oc_cnt++;
         if (pr) begin
            pr_cnt++;
            if (got_lat == 0) begin got_lat = cyc; res_pr = res; end
         end
         if (segura && got_lat == 0) drive(w, $urandom, $urandom, ~s, 1'b1);
         else drive(w, a, b, s, 1'b0);
      end
      vectors++;
      if (pr_cnt != 1) begin
         miscompares++;
         $display("FAIL %s pronto_pulses: got %0d expected 1", nome, pr_cnt);
      end
      vectors++;
      if (got_lat != exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d expected %0d", nome, got_lat, exp_lat);
      end
      vectors++;
      if (oc_cnt != exp_lat - 1) begin
         miscompares++;
         $display("FAIL %s ocupado_cycles: got %0d expected %0d", nome, oc_cnt, exp_lat - 1);
      end
      vectors++;
      if (res_pr !== exp_res) begin
         miscompares++;
         $display("FAIL %s result_at_pronto: got %b expected %b (a=%h b=%h s=%b)",
                  nome, res_pr, exp_res, a, b, s);
      end
      sample(w, oc, pr, res);
      vectors++;
      if (res !== exp_res) begin
         miscompares++;
         $display("FAIL %s result_hold: got %b expected %b", nome, res, exp_res);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 1'b0, 1'b0);
      drive(1, 0, 0, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      vectors++;
      if ({oc16, pr16, ig16, ma16, me16, oc8, pr8, ig8, ma8, me8} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {oc16, pr16, ig16, ma16, me16, oc8, pr8, ig8, ma8, me8});
      end
      reset_n = 1'b1;
      @(negedge clock);
      vectors++;
      if ({oc16, pr16, ig16, ma16, me16} !== 5'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: got %b expected 0", {oc16, pr16, ig16, ma16, me16});
      end
   endtask

   task automatic test_directed();
      test_compare(0, 32'hBEEF, 32'hBEEF, 1'b0, "eq_beef", 1'b0);
      test_compare(0, 32'h9000, 32'h1FFF, 1'b0, "gt_digit0", 1'b0);
      test_compare(0, 32'h1234, 32'h1235, 1'b0, "lt_digit3", 1'b0);
      test_compare(0, 32'hFFFF, 32'h0001, 1'b1, "signed_m1_vs_1", 1'b0);
      test_compare(0, 32'hFFFF, 32'h0001, 1'b0, "unsigned_ffff_vs_1", 1'b0);
      test_compare(0, 32'h8000, 32'h7FFF, 1'b1, "signed_min_vs_max", 1'b0);
   endtask

   task automatic test_inicio_held();
      test_compare(0, 32'h1234, 32'h1235, 1'b0, "inicio_held", 1'b1);
   endtask

   task automatic test_digito1();
      test_compare(1, 32'hA5, 32'hA5, 1'b0, "d1_equal", 1'b0);
      test_compare(1, 32'h80, 32'h7F, 1'b1, "d1_signed", 1'b0);
   endtask

   task automatic test_reset_abort();
      int pulses;
      @(negedge clock);
      drive(0, 32'hBEEF, 32'hBEEF, 1'b0, 1'b1);
      @(negedge clock);
      drive(0, 32'hBEEF, 32'hBEEF, 1'b0, 1'b0);
      @(negedge clock);
      vectors++;
      if (oc16 !== 1'b1 || pr16 !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_pre: got oc=%b pr=%b expected oc=1 pr=0", oc16, pr16);
      end
      reset_n = 1'b0;
      @(negedge clock);
      vectors++;
      if ({oc16, pr16, ig16, ma16, me16} !== 5'b0) begin
         miscompares++;
         $display("FAIL abort_outputs: got %b expected 0", {oc16, pr16, ig16, ma16, me16});
      end
      reset_n = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(negedge clock);
         if (pr16) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL abort_no_pronto: got %0d pulses expected 0", pulses);
      end
      test_compare(0, 32'h00F0, 32'h00E0, 1'b0, "after_abort", 1'b0);
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clock);
      drive(0, 32'h9000, 32'h1FFF, 1'b0, 1'b1);
      lat = 0;
      for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
         @(negedge clock);
         drive(0, 32'h9000, 32'h1FFF, 1'b0, 1'b0);
         if (pr16) lat = cyc;
      end
      vectors++;
      if (lat != 2) begin
         miscompares++;
         $display("FAIL b2b_first_latency: got %0d expected 2", lat);
      end
      @(negedge clock);
      vectors++;
      if ({oc16, pr16, ig16, ma16, me16} !== 5'b00010) begin
         miscompares++;
         $display("FAIL b2b_idle_cycle: got %b expected 00010", {oc16, pr16, ig16, ma16, me16});
      end
      drive(0, 32'h1234, 32'h1235, 1'b0, 1'b1);
      lat = 0;
      for (int cyc = 1; cyc <= 10 && lat == 0; cyc++) begin
         @(negedge clock);
         drive(0, 32'h1234, 32'h1235, 1'b0, 1'b0);
         if (pr16) lat = cyc;
      end
      vectors++;
      if (lat != 5) begin
         miscompares++;
         $display("FAIL b2b_second_latency: got %0d expected 5", lat);
      end
      vectors++;
      if ({ig16, ma16, me16} !== 3'b001) begin
         miscompares++;
         $display("FAIL b2b_second_result: got %b expected 001", {ig16, ma16, me16});
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      int lw;
      for (int i = 0; i < 60; i++) begin
         int w;
         w  = (i < 40) ? 0 : 1;
         lw = (w == 1) ? 8 : 16;
         a  = $urandom;
         case ($urandom_range(0, 2))
            0:       b = $urandom;
            1:       b = a;
            default: b = a ^ (32'h1 << $urandom_range(0, lw - 1));
         endcase
         test_compare(w, a, b, 1'($urandom_range(0, 1)), "random", 1'b0);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_inicio_held();
      test_digito1();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
